// File: rtl/snn_ec_pkg.sv
// Shared types and helpers for the spike event sequencer.
//   seq_state_e : sequencer FSM states (idle, encode, dispatch, wait, fire)
//   wait_len()  : cycles the neural units need per dispatched event
package snn_ec_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StEncode,
        StDispatch,
        StWait,
        StFire
    } seq_state_e;

    // A zero-length window would make the wait counter compare underflow, so clamp to 1.
    function automatic int unsigned wait_len(input int unsigned neural_size,
                                             input int unsigned cyc_per_neuron);
        int unsigned len;
        len = neural_size * cyc_per_neuron;
        return (len == 0) ? 1 : len;
    endfunction

endpackage

// File: rtl/spike_event_sequencer_if.sv
// Handshake bundle between the sequencer, its spike-vector source and its neural units.
//   pre_valid/pre_ready/pre_spk       : spike-vector input channel (sequencer is the sink)
//   evt_valid/evt_ready/evt_addr/last : event output channel (sequencer is the source)
// Modport master is the sequencer view, slave is the surrounding-logic view.
interface spike_event_sequencer_if #(
    parameter int unsigned SPK_WIDTH = 32
) ();
    localparam int unsigned ADDR_W = $clog2(SPK_WIDTH);

    logic                 pre_valid;
    logic                 pre_ready;
    logic [SPK_WIDTH-1:0] pre_spk;
    logic                 evt_valid;
    logic                 evt_ready;
    logic [ADDR_W-1:0]    evt_addr;
    logic                 evt_last;

    modport master (
        input  pre_valid,
        input  pre_spk,
        input  evt_ready,
        output pre_ready,
        output evt_valid,
        output evt_addr,
        output evt_last
    );

    modport slave (
        output pre_valid,
        output pre_spk,
        output evt_ready,
        input  pre_ready,
        input  evt_valid,
        input  evt_addr,
        input  evt_last
    );
endinterface

// File: rtl/spk_penc.sv
// Combinational lowest-set-bit priority encoder.
//   i_vec  : input vector
//   o_addr : index of the lowest set bit (0 when i_vec is zero)
//   o_any  : at least one bit of i_vec is set
module spk_penc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]         i_vec,
    output logic [$clog2(WIDTH)-1:0] o_addr,
    output logic                     o_any
);
    always_comb begin
        o_addr = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_addr = ($clog2(WIDTH))'(i);
            end
        end
    end

    assign o_any = |i_vec;
endmodule

// File: rtl/spike_event_sequencer.sv
// Spike event sequencer: compresses a pre-synaptic spike vector into an ordered stream of
// source addresses, dispatches each one to the neural units, waits out the per-event
// processing window, then captures the post-synaptic spikes to close the time step.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_flush          : synchronous abort to idle (time step and post spikes kept)
//   bus              : pre-spike input channel and event output channel
//   o_en_accum       : accumulation phase active (dispatch + wait)
//   i_post_avail     : i_neuron_spk_in is final for this time step
//   i_neuron_spk_in  : neuron output spikes
//   o_post_spk_out   : registered post-synaptic spikes
//   o_en_activ       : one-cycle pulse, o_post_spk_out updated
//   o_time_step      : current time step
//   o_ts_last        : one-cycle pulse alongside o_en_activ on the final time step
//   o_evt_count      : events found in the current vector
module spike_event_sequencer
    import snn_ec_pkg::*;
#(
    parameter int unsigned SPK_WIDTH      = 32,
    parameter int unsigned POST_WIDTH     = 32,
    parameter int unsigned NEURAL_SIZE    = 2,
    parameter int unsigned CYC_PER_NEURON = 2,
    parameter int unsigned NUM_TS         = 25,
    parameter int unsigned ADDR_W         = $clog2(SPK_WIDTH),
    parameter int unsigned TS_W           = $clog2(NUM_TS)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_flush,
    spike_event_sequencer_if.master bus,
    output logic                    o_en_accum,
    input  logic                    i_post_avail,
    input  logic [POST_WIDTH-1:0]   i_neuron_spk_in,
    output logic [POST_WIDTH-1:0]   o_post_spk_out,
    output logic                    o_en_activ,
    output logic [TS_W-1:0]         o_time_step,
    output logic                    o_ts_last,
    output logic [ADDR_W:0]         o_evt_count
);
    localparam int unsigned WAIT_LEN = wait_len(NEURAL_SIZE, CYC_PER_NEURON);
    localparam int unsigned WAIT_W   = (WAIT_LEN > 1) ? $clog2(WAIT_LEN) : 1;

    seq_state_e              r_state, w_state_d;
    logic [SPK_WIDTH-1:0]    r_work, w_work_d;
    logic [ADDR_W:0]         r_evt_count, w_evt_count_d;
    logic [ADDR_W-1:0]       r_rd_ptr, w_rd_ptr_d;
    logic [WAIT_W-1:0]       r_wait_cnt, w_wait_cnt_d;
    logic [ADDR_W-1:0]       r_addr_buf [SPK_WIDTH];

    logic                    r_pre_ready, w_pre_ready_d;
    logic                    r_evt_valid, w_evt_valid_d;
    logic [ADDR_W-1:0]       r_evt_addr, w_evt_addr_d;
    logic                    r_evt_last, w_evt_last_d;
    logic                    r_en_accum, w_en_accum_d;
    logic [POST_WIDTH-1:0]   r_post_spk, w_post_spk_d;
    logic                    r_en_activ, w_en_activ_d;
    logic [TS_W-1:0]         r_time_step, w_time_step_d;
    logic                    r_ts_last, w_ts_last_d;

    logic [ADDR_W-1:0]       w_penc_addr;
    logic                    w_penc_any;
    logic                    w_buf_we;
    logic                    w_at_last_evt;

    spk_penc #(
        .WIDTH (SPK_WIDTH)
    ) u_penc (
        .i_vec  (r_work),
        .o_addr (w_penc_addr),
        .o_any  (w_penc_any)
    );

    assign w_at_last_evt = ({1'b0, r_rd_ptr} == (r_evt_count - 1'b1));

    always_comb begin
        w_state_d     = r_state;
        w_work_d      = r_work;
        w_evt_count_d = r_evt_count;
        w_rd_ptr_d    = r_rd_ptr;
        w_wait_cnt_d  = r_wait_cnt;
        w_post_spk_d  = r_post_spk;
        w_time_step_d = r_time_step;
        w_en_activ_d  = 1'b0;
        w_ts_last_d   = 1'b0;
        w_buf_we      = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (bus.pre_valid && r_pre_ready) begin
                    w_work_d      = bus.pre_spk;
                    w_evt_count_d = '0;
                    w_state_d     = StEncode;
                end
            end
            StEncode: begin
                if (w_penc_any) begin
                    w_buf_we      = 1'b1;
                    w_work_d      = r_work & (r_work - 1'b1);  // drop the lowest set bit
                    w_evt_count_d = r_evt_count + 1'b1;
                end else if (r_evt_count != '0) begin
                    w_rd_ptr_d = '0;
                    w_state_d  = StDispatch;
                end else begin
                    w_state_d = StFire;
                end
            end
            StDispatch: begin
                if (bus.evt_ready) begin
                    w_wait_cnt_d = '0;
                    w_state_d    = StWait;
                end
            end
            StWait: begin
                if (r_wait_cnt == WAIT_W'(WAIT_LEN - 1)) begin
                    if (w_at_last_evt) begin
                        w_rd_ptr_d = '0;
                        w_state_d  = StFire;
                    end else begin
                        w_rd_ptr_d = r_rd_ptr + 1'b1;
                        w_state_d  = StDispatch;
                    end
                end else begin
                    w_wait_cnt_d = r_wait_cnt + 1'b1;
                end
            end
            StFire: begin
                if (i_post_avail) begin
                    w_post_spk_d = i_neuron_spk_in;
                    w_en_activ_d = 1'b1;
                    if (r_time_step == TS_W'(NUM_TS - 1)) begin
                        w_time_step_d = '0;
                        w_ts_last_d   = 1'b1;
                    end else begin
                        w_time_step_d = r_time_step + 1'b1;
                    end
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase

        // Flush overrides every transition above but keeps the time-step results.
        if (i_flush) begin
            w_state_d     = StIdle;
            w_work_d      = '0;
            w_evt_count_d = '0;
            w_rd_ptr_d    = '0;
            w_wait_cnt_d  = '0;
            w_post_spk_d  = r_post_spk;
            w_time_step_d = r_time_step;
            w_en_activ_d  = 1'b0;
            w_ts_last_d   = 1'b0;
            w_buf_we      = 1'b0;
        end

        // Handshake outputs are registered from the next state so they line up with it.
        w_pre_ready_d = (w_state_d == StIdle);
        w_evt_valid_d = (w_state_d == StDispatch);
        w_en_accum_d  = (w_state_d == StDispatch) || (w_state_d == StWait);
        w_evt_addr_d  = w_evt_valid_d ? r_addr_buf[w_rd_ptr_d] : '0;
        w_evt_last_d  = w_evt_valid_d && ({1'b0, w_rd_ptr_d} == (w_evt_count_d - 1'b1));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_work      <= '0;
            r_evt_count <= '0;
            r_rd_ptr    <= '0;
            r_wait_cnt  <= '0;
            r_pre_ready <= 1'b1;
            r_evt_valid <= 1'b0;
            r_evt_addr  <= '0;
            r_evt_last  <= 1'b0;
            r_en_accum  <= 1'b0;
            r_post_spk  <= '0;
            r_en_activ  <= 1'b0;
            r_time_step <= '0;
            r_ts_last   <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_work      <= w_work_d;
            r_evt_count <= w_evt_count_d;
            r_rd_ptr    <= w_rd_ptr_d;
            r_wait_cnt  <= w_wait_cnt_d;
            r_pre_ready <= w_pre_ready_d;
            r_evt_valid <= w_evt_valid_d;
            r_evt_addr  <= w_evt_addr_d;
            r_evt_last  <= w_evt_last_d;
            r_en_accum  <= w_en_accum_d;
            r_post_spk  <= w_post_spk_d;
            r_en_activ  <= w_en_activ_d;
            r_time_step <= w_time_step_d;
            r_ts_last   <= w_ts_last_d;
        end
    end

    // Address buffer holds data only; entries are always written before they are read.
    always_ff @(posedge i_clk) begin
        if (w_buf_we) begin
            r_addr_buf[r_evt_count[ADDR_W-1:0]] <= w_penc_addr;
        end
    end

    assign bus.pre_ready  = r_pre_ready;
    assign bus.evt_valid  = r_evt_valid;
    assign bus.evt_addr   = r_evt_addr;
    assign bus.evt_last   = r_evt_last;
    assign o_en_accum     = r_en_accum;
    assign o_post_spk_out = r_post_spk;
    assign o_en_activ     = r_en_activ;
    assign o_time_step    = r_time_step;
    assign o_ts_last      = r_ts_last;
    assign o_evt_count    = r_evt_count;
endmodule

// File: tb/tb_spike_event_sequencer.sv
module tb_spike_event_sequencer;
    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        en_accum;
    logic        post_avail;
    logic [31:0] neuron_spk_in;
    logic [31:0] post_spk_out;
    logic        en_activ;
    logic [4:0]  time_step;
    logic        ts_last;
    logic [5:0]  evt_count;

    int n_tests = 0;
    int n_fail  = 0;
    int ts_model = 0;
    int ts_last_seen = 0;
    logic [31:0] exp_post = '0;

    spike_event_sequencer_if #(.SPK_WIDTH(32)) bus_if ();

    spike_event_sequencer #(
        .SPK_WIDTH      (32),
        .POST_WIDTH     (32),
        .NEURAL_SIZE    (2),
        .CYC_PER_NEURON (2),
        .NUM_TS         (25)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_flush         (flush),
        .bus             (bus_if),
        .o_en_accum      (en_accum),
        .i_post_avail    (post_avail),
        .i_neuron_spk_in (neuron_spk_in),
        .o_post_spk_out  (post_spk_out),
        .o_en_activ      (en_activ),
        .o_time_step     (time_step),
        .o_ts_last       (ts_last),
        .o_evt_count     (evt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends one vector and follows it to its en_activ pulse. Expected events are the set bits
    // in ascending order; with evt_ready held high the first event appears popcount+1 cycles
    // after capture, events are 5 cycles apart and en_activ lands 6*popcount+2 cycles after.
    // mode: 0 = ready always high, 1 = ready toggling, 2 = ready random.
    task automatic run_vector(input logic [31:0] v, input int mode, input logic [31:0] nspk);
        int exp_q[$];
        int pc, k, first_k, last_hs, n_got, old_ts;
        bit done, prev_stall, rdy;
        logic [4:0] prev_addr;
        exp_q = {};
        for (int i = 0; i < 32; i++) if (v[i]) exp_q.push_back(i);
        pc = exp_q.size();
        old_ts = ts_model;
        check("pre_ready_idle", bus_if.pre_ready, 1'b1);
        bus_if.pre_valid = 1'b1;
        bus_if.pre_spk   = v;
        neuron_spk_in    = nspk;
        post_avail       = 1'b1;
        bus_if.evt_ready = 1'b0;
        @(negedge clk);
        bus_if.pre_valid = 1'b0;
        bus_if.pre_spk   = $urandom();  // must not disturb the captured vector
        k = 0; first_k = -1; last_hs = -1; n_got = 0;
        done = 1'b0; prev_stall = 1'b0; prev_addr = '0;
        while (!done && k < 2000) begin
            if (prev_stall) begin
                check("stall_valid", bus_if.evt_valid, 1'b1);
                check("stall_addr", bus_if.evt_addr, prev_addr);
            end
            if (bus_if.evt_valid === 1'b1) begin
                check("en_accum_dispatch", en_accum, 1'b1);
                if (first_k < 0) begin
                    first_k = k;
                    check("evt_count", evt_count, pc);
                    if (mode == 0) check("first_latency", k, pc + 1);
                end
            end
            if (en_activ === 1'b1) begin
                ts_model = (ts_model + 1) % 25;
                exp_post = nspk;
                if (ts_last === 1'b1) ts_last_seen++;
                check("post_spk_out", post_spk_out, nspk);
                check("time_step", time_step, ts_model);
                check("ts_last", ts_last, old_ts == 24);
                check("pre_ready_after", bus_if.pre_ready, 1'b1);
                check("en_accum_fire", en_accum, 1'b0);
                check("evt_valid_fire", bus_if.evt_valid, 1'b0);
                check("events_seen", n_got, pc);
                if (mode == 0) check("activ_latency", k, 6 * pc + 2);
                done = 1'b1;
            end else begin
                if (mode == 0) rdy = 1'b1;
                else if (mode == 1) rdy = (k % 2) == 0;
                else rdy = $urandom_range(0, 1) == 1;
                bus_if.evt_ready = rdy;
                if (bus_if.evt_valid === 1'b1 && rdy) begin
                    if (n_got < pc) check("evt_addr", bus_if.evt_addr, exp_q[n_got]);
                    else check("evt_extra", n_got, pc);
                    check("evt_last", bus_if.evt_last, n_got == pc - 1);
                    if (mode == 0 && last_hs >= 0) check("evt_spacing", k - last_hs, 5);
                    last_hs = k;
                    n_got++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = (bus_if.evt_valid === 1'b1);
                end
                prev_addr = bus_if.evt_addr;
                @(negedge clk);
                k++;
            end
        end
        check("vector_done", done, 1'b1);
        bus_if.evt_ready = 1'b0;
        @(negedge clk);
        check("en_activ_pulse", en_activ, 1'b0);
        check("ts_last_pulse", ts_last, 1'b0);
    endtask

    initial begin
        int k;
        logic [31:0] v;
        logic [31:0] post_before;
        rst_n = 1'b0;
        flush = 1'b0;
        post_avail = 1'b0;
        neuron_spk_in = '0;
        bus_if.pre_valid = 1'b0;
        bus_if.pre_spk = '0;
        bus_if.evt_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_pre_ready", bus_if.pre_ready, 1'b1);
        check("rst_evt_valid", bus_if.evt_valid, 1'b0);
        check("rst_time_step", time_step, 0);
        check("rst_post_spk", post_spk_out, 0);
        check("rst_evt_count", evt_count, 0);
        check("rst_en_activ", en_activ, 1'b0);

        run_vector(32'h0000_0105, 0, 32'hA5A5_0001);
        run_vector(32'h0000_0000, 0, 32'h1234_5678);
        run_vector(32'hFFFF_FFFF, 1, 32'h0F0F_F0F0);

        // Asynchronous reset while an event is being offered.
        bus_if.pre_valid = 1'b1;
        bus_if.pre_spk = 32'h0000_0105;
        @(negedge clk);
        bus_if.pre_valid = 1'b0;
        k = 0;
        while (bus_if.evt_valid !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("rst_reach_dispatch", bus_if.evt_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_evt_valid", bus_if.evt_valid, 1'b0);
        check("arst_evt_addr", bus_if.evt_addr, 0);
        check("arst_evt_last", bus_if.evt_last, 1'b0);
        check("arst_en_accum", en_accum, 1'b0);
        check("arst_evt_count", evt_count, 0);
        check("arst_time_step", time_step, 0);
        check("arst_post_spk", post_spk_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_pre_ready", bus_if.pre_ready, 1'b1);
        check("arst_idle_valid", bus_if.evt_valid, 1'b0);
        ts_model = 0;
        exp_post = '0;

        // 25 back-to-back vectors: time step wraps once with a single ts_last.
        ts_last_seen = 0;
        for (int n = 0; n < 25; n++) begin
            run_vector($urandom() & $urandom(), int'($urandom_range(0, 2)), $urandom());
        end
        check("ts_wrap", time_step, 0);
        check("ts_last_count", ts_last_seen, 1);

        // Flush during the wait window of a 3-event vector.
        v = '0;
        while ($countones(v) < 3) v[$urandom_range(0, 31)] = 1'b1;
        post_before = exp_post;
        bus_if.pre_valid = 1'b1;
        bus_if.pre_spk = v;
        neuron_spk_in = $urandom();
        @(negedge clk);
        bus_if.pre_valid = 1'b0;
        bus_if.evt_ready = 1'b1;
        k = 0;
        while (bus_if.evt_valid !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("flush_reach_dispatch", bus_if.evt_valid, 1'b1);
        @(negedge clk);
        check("wait_no_valid", bus_if.evt_valid, 1'b0);
        check("wait_en_accum", en_accum, 1'b1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bus_if.evt_ready = 1'b0;
        check("flush_pre_ready", bus_if.pre_ready, 1'b1);
        check("flush_evt_valid", bus_if.evt_valid, 1'b0);
        check("flush_en_accum", en_accum, 1'b0);
        check("flush_evt_count", evt_count, 0);
        check("flush_time_step", time_step, ts_model);
        check("flush_post_spk", post_spk_out, post_before);
        check("flush_en_activ", en_activ, 1'b0);
        @(negedge clk);
        run_vector(v, 0, $urandom());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
